// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and types for the data memory responder:
//                RV32I load/store size encodings, FSM state enum, latency
//                bounds and the access-legality decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] c_FUNCT3_B  = 3'b000;
    localparam logic [2:0] c_FUNCT3_H  = 3'b001;
    localparam logic [2:0] c_FUNCT3_W  = 3'b010;
    localparam logic [2:0] c_FUNCT3_BU = 3'b100;
    localparam logic [2:0] c_FUNCT3_HU = 3'b101;

    // Legal request-to-response latency range (4-bit wait counter)
    localparam int c_LATENCY_MIN = 1;
    localparam int c_LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size/alignment legality of an access; the range check lives in the top
    // because it depends on the storage depth.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (funct3)
            c_FUNCT3_B:  fault = 1'b0;
            c_FUNCT3_H:  fault = addr_lo[0];
            c_FUNCT3_W:  fault = (addr_lo != 2'b00);
            c_FUNCT3_BU: fault = we;
            c_FUNCT3_HU: fault = we | addr_lo[0];
            default:     fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering. Builds the byte write mask
//                and lane-replicated store data, and extracts/extends the
//                addressed byte or half from a read word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half out of the read word
    always_comb begin
        w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
        w_half = i_rword[{i_addr_lo[1], 4'b0000} +: 16];
    end

    // Size-dependent mask, replicated store data and extended load data
    always_comb begin
        o_wmask = 4'b0000;
        o_wdata = 32'd0;
        o_rdata = 32'd0;
        case (i_funct3)
            c_FUNCT3_B: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            c_FUNCT3_H: begin
                o_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_half[15]}}, w_half};
            end
            c_FUNCT3_W: begin
                o_wmask = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            c_FUNCT3_BU: o_rdata = {24'd0, w_byte};
            c_FUNCT3_HU: o_rdata = {16'd0, w_half};
            default: begin
                o_wmask = 4'b0000;
                o_wdata = 32'd0;
                o_rdata = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Fixed-latency RV32I data memory slave. One request at a
//                time: accept in IDLE, count down in WAIT, present the
//                response in RESP until the initiator takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Out-of-range latency values are clamped to what the counter can express
    localparam int c_LAT = (LATENCY < c_LATENCY_MIN) ? c_LATENCY_MIN :
                           (LATENCY > c_LATENCY_MAX) ? c_LATENCY_MAX : LATENCY;
    localparam logic [3:0] c_CNT_INIT = (c_LAT >= 2) ? 4'(c_LAT - 2) : 4'd0;
    localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_live;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_acc_we;
    logic [2:0]  w_acc_funct3;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic        w_in_range;
    logic        w_err;
    logic [c_IDX_W-1:0] w_word_idx;
    logic [31:0] w_rword;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata_ext;

    logic [31:0] r_mem [DEPTH_WORDS];

    // r_live holds req_ready low until the first edge after reset release
    assign req_ready = (r_state == ST_IDLE) && r_live;
    assign w_accept  = req_valid && req_ready;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) && r_rsp_err;
    assign rsp_rdata = (r_state == ST_RESP) ? r_rsp_rdata : 32'd0;

    // With a latency of one the access happens on the accept edge itself,
    // before the request registers are loaded, so use the live inputs then.
    assign w_acc_we     = (r_state == ST_IDLE) ? req_we     : r_we;
    assign w_acc_funct3 = (r_state == ST_IDLE) ? req_funct3 : r_funct3;
    assign w_acc_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
    assign w_acc_wdata  = (r_state == ST_IDLE) ? req_wdata  : r_wdata;

    assign w_in_range   = ({2'b00, w_acc_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_err        = access_fault(w_acc_we, w_acc_funct3, w_acc_addr[1:0]) | ~w_in_range;
    assign w_word_idx   = w_acc_addr[c_IDX_W+1:2];
    assign w_rword      = w_in_range ? r_mem[w_word_idx] : 32'd0;
    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    mem_lane_align u_lane_align (
        .i_funct3  (w_acc_funct3),
        .i_addr_lo (w_acc_addr[1:0]),
        .i_wdata   (w_acc_wdata),
        .i_rword   (w_rword),
        .o_wmask   (w_wmask),
        .o_wdata   (w_wdata_sh),
        .o_rdata   (w_rdata_ext)
    );

    // State register, wait counter and post-reset ready qualifier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_live  <= 1'b1;
        end
    end

    // Next-state and counter decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (c_LAT == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the request on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Latch the response on the edge entering RESP; stores and errors read 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else if (w_enter_resp) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || w_acc_we) ? 32'd0 : w_rdata_ext;
        end
    end

    // Commit legal stores on the edge entering RESP; storage is never reset
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_acc_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder with a
//                transaction-level reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_err    = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0]  m_mem [4*DEPTH_WORDS];
    int          m_phase;   // 0 free, 1 pending, 2 answering
    int          m_left;
    bit          m_live;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic model_resolve();
        int          sz;
        bit          ok;
        logic [31:0] v;
        sz = (m_f3[1:0] == 2'd0) ? 1 : (m_f3[1:0] == 2'd1) ? 2 : 4;
        ok = m_we ? (m_f3 <= 3'd2) : (m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (ok) ok = (m_addr % sz) == 0;
        if (ok) ok = (m_addr / 4) < DEPTH_WORDS;
        m_err   = !ok;
        m_rdata = 32'd0;
        if (ok) begin
            if (m_we) begin
                for (int i = 0; i < sz; i++) m_mem[m_addr + i] = m_wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(m_mem[m_addr + i]) << (8*i));
                if (!m_f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
                m_rdata = v;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_left  = 0;
            m_live  = 0;
            m_err   = 0;
            m_rdata = 0;
        end else begin
            case (m_phase)
                0: if (req_valid && m_live) begin
                    m_we = req_we; m_f3 = req_funct3; m_addr = req_addr; m_wd = req_wdata;
                    m_left = LATENCY - 1;
                    if (m_left == 0) begin model_resolve(); m_phase = 2; end
                    else m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin model_resolve(); m_phase = 2; end
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
            m_live = 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        check("cyc_rsp_err",   32'(rsp_err),   (m_phase == 2) ? 32'(m_err) : 32'd0);
        check("cyc_rsp_rdata", rsp_rdata,      (m_phase == 2) ? m_rdata : 32'd0);
        if (rst) check("cyc_req_ready", 32'(req_ready), 32'(m_phase == 0));
    end

    // One transaction with literal expectations; stall = cycles rsp_ready held low in RESP
    task automatic run(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int stall,
                       input logic [31:0] exp_rd, input logic exp_er);
        int lat;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        // A stray store kept on the bus while busy must be ignored
        req_we = 1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 0;
        rd = rsp_rdata;
        er = rsp_err;
        check({name, "_latency"}, lat, LATENCY);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(er), 32'(exp_er));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({name, "_hold_rdata"}, rsp_rdata, exp_rd);
            check({name, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check({name, "_ready_after_hs"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        //   name        we  f3      addr          wdata         stall exp_rdata     err
        run("SW_20",     1, 3'b010, 32'h20,       32'hA5A50F0F, 0, 32'h0,        0);
        run("SW_10",     1, 3'b010, 32'h10,       32'hDEADBEEF, 0, 32'h0,        0);
        run("LW_10",     0, 3'b010, 32'h10,       32'h0,        0, 32'hDEADBEEF, 0);
        run("LB_13",     0, 3'b000, 32'h13,       32'h0,        0, 32'hFFFFFFDE, 0);
        run("LBU_13",    0, 3'b100, 32'h13,       32'h0,        0, 32'h000000DE, 0);
        run("LH_12",     0, 3'b001, 32'h12,       32'h0,        0, 32'hFFFFDEAD, 0);
        run("LHU_10",    0, 3'b101, 32'h10,       32'h0,        0, 32'h0000BEEF, 0);
        run("SB_11",     1, 3'b000, 32'h11,       32'h00000055, 0, 32'h0,        0);
        run("LW_10b",    0, 3'b010, 32'h10,       32'h0,        0, 32'hDEAD55EF, 0);
        run("SW_12_mis", 1, 3'b010, 32'h12,       32'h11111111, 0, 32'h0,        1);
        run("SST_f3_4",  1, 3'b100, 32'h10,       32'h22222222, 0, 32'h0,        1);
        run("LW_10c",    0, 3'b010, 32'h10,       32'h0,        0, 32'hDEAD55EF, 0);
        run("LW_400",    0, 3'b010, 32'h400,      32'h0,        0, 32'h0,        1);
        run("LD_f3_3",   0, 3'b011, 32'h10,       32'h0,        0, 32'h0,        1);
        run("LD_f3_6",   0, 3'b110, 32'h10,       32'h0,        0, 32'h0,        1);
        run("LH_11_mis", 0, 3'b001, 32'h11,       32'h0,        0, 32'h0,        1);
        run("LW_stall",  0, 3'b010, 32'h10,       32'h0,        5, 32'hDEAD55EF, 0);
        run("SH_22",     1, 3'b001, 32'h22,       32'hFFFF1234, 0, 32'h0,        0);
        run("LW_20",     0, 3'b010, 32'h20,       32'h0,        0, 32'h12340F0F, 0);

        // Reset while a store is waiting: no response, no write
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        rsp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (LATENCY + 4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        check("rst_wait_no_rsp", 32'(seen), 32'd0);
        rsp_ready = 0;
        run("LW_20_post", 0, 3'b010, 32'h20, 32'h0, 0, 32'h12340F0F, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit storage words.
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request accept to rsp_valid; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  input  1  SHALL mean the initiator presents a request.
REQ-006 req_ready  output  1  SHALL mean the block can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_funct3  input  3  SHALL give the RV32I access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  32  SHALL be the byte address.
REQ-010 req_wdata  input  32  SHALL be the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  SHALL mean a response is presented.
REQ-012 rsp_ready  input  1  SHALL mean the initiator takes the response this cycle.
REQ-013 rsp_rdata  output  32  SHALL be the load data, extended to 32 bits.
REQ-014 rsp_err  output  1  SHALL flag a rejected access.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept on req_valid&req_ready SHALL capture we, funct3, addr and wdata. If LATENCY=1, the FSM SHALL go to RESP; otherwise it SHALL go to WAIT with the counter loaded to LATENCY-2.
REQ-017 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter equals 0.
REQ-018 The memory access (store commit, load read) SHALL occur on the edge entering RESP, so rsp_valid is first high exactly LATENCY cycles after the accept edge.
REQ-019 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE; a new request SHALL NOT be accepted in the handshake cycle.
REQ-020 Loads: B/H SHALL sign-extend; BU/HU SHALL zero-extend; the byte lane is addr[1:0] and the half lane is addr[1].
REQ-021 Stores SHALL write only the addressed lanes (SB 1 byte, SH 2 bytes, SW 4 bytes); rsp_rdata SHALL be 0 for stores.
REQ-022 Error conditions SHALL be: half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS; load funct3 of 011, 110 or 111; store funct3 >= 011.
REQ-023 On error, the block SHALL NOT write memory, SHALL set rsp_err=1 and rsp_rdata=0, and SHALL keep the same latency.
REQ-024 req_* inputs SHALL be ignored outside IDLE, and rsp_ready SHALL be ignored outside RESP.
REQ-025 Outside RESP, rsp_valid, rsp_err and rsp_rdata SHALL be 0.

Reset
REQ-026 While rst=0, the FSM SHALL be in IDLE, the counter 0, and rsp_valid, rsp_err and rsp_rdata 0; req_ready SHALL be 1 one cycle after rst deasserts.
REQ-027 Reset in WAIT SHALL drop the pending request, and an uncommitted store SHALL NOT write memory.
REQ-028 Memory contents SHALL NOT be reset.

Structure
REQ-029 Package mem_pkg SHALL hold the funct3 constants, the FSM state enum and the LATENCY bounds.
REQ-030 Sub-module mem_lane_align SHALL be combinational and produce the write byte-mask, the shifted write data and the extended load data.

Verification
REQ-031 LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after each accept.
REQ-032 After REQ-031: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
REQ-034 SW 0x12 -> err 1, no write (LW 0x10 unchanged); LW 0x400 with DEPTH_WORDS=256 -> err 1, rdata 0; load funct3 011 -> err 1.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready 0; on the handshake cycle -> IDLE, with req_ready 1 the next cycle.
REQ-036 rst pulsed low during WAIT of SW 0x20 data 0x12345678 -> no response, and a later LW 0x20 returns the prior contents.
